imem_fetch_sequencer: RTL and testbench

- Sequences the pipeline's instruction fetch from the byte-addressed, big-endian, combinational-read instruction memory (1024 bytes; returns the 32-bit word starting at the addressed byte).
- Generates the memory fetch address and captures returned words into a small prefetch queue.
- Presents {pc, instruction} to the IF/ID boundary and handles stall, redirect (branch/jump) flush, and illegal-address faults.
- Sits between the PC logic of the pipeline and the instruction memory, replacing the bare PC register.

---
 rtl/pipeline_pkg.sv | 18 +
 rtl/fetch_queue.sv | 59 +++++
 rtl/imem_fetch_sequencer.sv | 93 +++++++++
 tb/tb_imem_fetch_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared fetch-path types and constants for the pipeline front end.
package pipeline_pkg;

   localparam int INSTR_W    = 32;
   localparam int WORD_BYTES = 4;
   localparam int PC_W       = 32;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO for prefetched {pc, instr} entries; flush wins over push/pop,
// and a push into a full queue is accepted when a pop happens on the same edge.
module fetch_queue #(
   parameter int W     = 64,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic         full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             pop_eff;
   logic             push_eff;

   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));
   assign pop_eff  = pop && !empty;
   assign push_eff = push && (!full || pop_eff);
   // Empty reads as zero so the head never exposes stale storage.
   assign dout     = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (pop_eff)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push_eff) wr_ptr <= wr_ptr + PTR_W'(1);
         case ({push_eff, pop_eff})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_eff && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/imem_fetch_sequencer.sv
// Instruction fetch sequencer: PC register, address legality, RUN/FAULT control,
// and a prefetch queue feeding the IF/ID boundary.
module imem_fetch_sequencer
   import pipeline_pkg::*;
#(
   parameter int              ADDR_W    = 32,
   parameter int              MEM_BYTES = 1024,
   parameter int              DEPTH     = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] imem_pc,
   input  logic [INSTR_W-1:0] imem_instr,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0] if_pc,
   output logic [ADDR_W-1:0] if_pc_plus4,
   output logic              fetch_fault
);

   localparam int E_W = ADDR_W + INSTR_W;

   fetch_state_t      state;
   fetch_state_t      state_nxt;
   logic [ADDR_W-1:0] pc_nxt;
   logic [ADDR_W-1:0] seq_pc;
   logic              push;
   logic              pop;
   logic              q_empty;
   logic              q_full;
   logic [E_W-1:0]    q_head;

   function automatic logic is_legal(input logic [ADDR_W-1:0] a);
      return (a[1:0] == 2'b00) && (a <= ADDR_W'(MEM_BYTES - WORD_BYTES));
   endfunction

   assign seq_pc = imem_pc + ADDR_W'(WORD_BYTES);
   assign pop    = if_valid && !stall && !redirect_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RUN;
         imem_pc <= RESET_PC;
      end else begin
         state   <= state_nxt;
         imem_pc <= pc_nxt;
      end
   end

   // An illegal imem_pc in RUN (sequential overrun) moves to FAULT one edge after the last push.
   always_comb begin
      state_nxt = state;
      pc_nxt    = imem_pc;
      push      = 1'b0;
      if (redirect_valid) begin
         pc_nxt    = redirect_pc;
         state_nxt = is_legal(redirect_pc) ? RUN : FAULT;
      end else if (state == RUN) begin
         if (!is_legal(imem_pc)) begin
            state_nxt = FAULT;
         end else if (!q_full || pop) begin
            push   = 1'b1;
            pc_nxt = seq_pc;
         end
      end
   end

   fetch_queue #(
      .W     (E_W),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect_valid),
      .push  (push),
      .pop   (pop),
      .din   ({imem_pc, imem_instr}),
      .dout  (q_head),
      .empty (q_empty),
      .full  (q_full)
   );

   assign if_valid    = !q_empty;
   assign if_pc       = q_head[E_W-1:INSTR_W];
   assign if_instr    = q_head[INSTR_W-1:0];
   assign if_pc_plus4 = if_valid ? (if_pc + ADDR_W'(WORD_BYTES)) : '0;
   assign fetch_fault = (state == FAULT);

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Bench for imem_fetch_sequencer: directed vector table, reset corner case, and
// randomized stall/redirect traffic checked against a queue-based reference model.
module tb_imem_fetch_sequencer;

   localparam int DEPTH     = 2;
   localparam int MEM_BYTES = 1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] imem_pc;
   logic [31:0] imem_instr;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic        fetch_fault;

   always #5 clk = ~clk;

   imem_fetch_sequencer #(
      .ADDR_W    (32),
      .MEM_BYTES (MEM_BYTES),
      .DEPTH     (DEPTH),
      .RESET_PC  (32'h0)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_pc        (imem_pc),
      .imem_instr     (imem_instr),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_pc_plus4    (if_pc_plus4),
      .fetch_fault    (fetch_fault)
   );

   // Program image and big-endian byte memory
   function automatic logic [31:0] img_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h0000_0820;
         32'h4:   return 32'h8C22_03E8;
         32'h8:   return 32'h0040_1820;
         default: return 32'hC0DE_0000 | {16'h0, a[15:0]};
      endcase
   endfunction

   logic [7:0] mem [MEM_BYTES];
   logic [9:0] ia;
   assign ia = imem_pc[9:0];
   assign imem_instr = {mem[ia], mem[ia + 10'd1], mem[ia + 10'd2], mem[ia + 10'd3]};

   // Reference model: queue of fetched PCs, next fetch address, fault flag
   logic [31:0] exp_q[$];
   logic [31:0] m_pc;
   logic        m_fault;
   int          n_cmp = 0;
   int          n_err = 0;

   function automatic logic legal(input logic [31:0] a);
      return (a % 4 == 0) && (a <= MEM_BYTES - 4);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_pc    = 32'h0;
      m_fault = 1'b0;
   endtask

   task automatic model_edge(input logic s, input logic r, input logic [31:0] rpc);
      logic do_pop, do_push, overrun;
      if (r) begin
         exp_q.delete();
         m_pc    = rpc;
         m_fault = !legal(rpc);
      end else begin
         do_pop  = (exp_q.size() > 0) && !s;
         do_push = !m_fault && legal(m_pc) && ((exp_q.size() < DEPTH) || do_pop);
         overrun = !m_fault && !legal(m_pc);
         if (do_pop) void'(exp_q.pop_front());
         if (do_push) begin
            exp_q.push_back(m_pc);
            m_pc = m_pc + 4;
         end
         if (overrun) m_fault = 1'b1;
      end
   endtask

   task automatic compare_model();
      logic        ev;
      logic [31:0] epc;
      ev  = exp_q.size() > 0;
      epc = ev ? exp_q[0] : 32'h0;
      chk("m_if_valid", {31'h0, if_valid}, {31'h0, ev});
      chk("m_if_pc", if_pc, epc);
      chk("m_if_instr", if_instr, ev ? img_word(epc) : 32'h0);
      chk("m_if_pc_plus4", if_pc_plus4, ev ? epc + 32'd4 : 32'h0);
      chk("m_imem_pc", imem_pc, m_pc);
      chk("m_fetch_fault", {31'h0, fetch_fault}, {31'h0, m_fault});
   endtask

   // Called at negedge+1: check, drive, advance one clock
   task automatic run_cycle(input logic s, input logic r, input logic [31:0] rpc);
      compare_model();
      stall          = s;
      redirect_valid = r;
      redirect_pc    = rpc;
      @(posedge clk);
      model_edge(s, r, rpc);
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n          = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      #1;
   endtask

   typedef struct {
      logic        rst;
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_imem;
      logic        exp_fault;
   } vec_t;

   vec_t vec [28];

   function automatic vec_t mk(input logic rst, input logic s, input logic r, input logic [31:0] rpc,
                               input logic ev, input logic [31:0] epc, input logic [31:0] eim,
                               input logic ef);
      vec_t v;
      v.rst = rst; v.stall = s; v.redir = r; v.rpc = rpc;
      v.exp_valid = ev; v.exp_pc = epc; v.exp_imem = eim; v.exp_fault = ef;
      return v;
   endfunction

   initial begin
      logic [31:0] w;
      logic [31:0] rpc;
      int          k;

      for (int a = 0; a < MEM_BYTES; a += 4) begin
         w = img_word(a);
         mem[a] = w[31:24]; mem[a+1] = w[23:16]; mem[a+2] = w[15:8]; mem[a+3] = w[7:0];
      end

      // rst, stall, redir, rpc, valid, pc, imem_pc, fault
      vec[0]  = mk(1, 0, 0, 0,      0, 32'h000, 32'h000, 0);
      vec[1]  = mk(0, 0, 0, 0,      1, 32'h000, 32'h004, 0);
      vec[2]  = mk(0, 0, 0, 0,      1, 32'h004, 32'h008, 0);
      vec[3]  = mk(0, 0, 0, 0,      1, 32'h008, 32'h00C, 0);
      vec[4]  = mk(1, 0, 0, 0,      0, 32'h000, 32'h000, 0);
      vec[5]  = mk(0, 1, 0, 0,      1, 32'h000, 32'h004, 0);
      vec[6]  = mk(0, 1, 0, 0,      1, 32'h000, 32'h008, 0);
      vec[7]  = mk(0, 1, 0, 0,      1, 32'h000, 32'h008, 0);
      vec[8]  = mk(0, 1, 0, 0,      1, 32'h000, 32'h008, 0);
      vec[9]  = mk(0, 0, 0, 0,      1, 32'h000, 32'h008, 0);
      vec[10] = mk(0, 0, 0, 0,      1, 32'h004, 32'h00C, 0);
      vec[11] = mk(0, 0, 0, 0,      1, 32'h008, 32'h010, 0);
      vec[12] = mk(0, 1, 1, 32'h18, 1, 32'h00C, 32'h014, 0);
      vec[13] = mk(0, 1, 0, 0,      0, 32'h000, 32'h018, 0);
      vec[14] = mk(0, 0, 1, 32'h1E, 1, 32'h018, 32'h01C, 0);
      vec[15] = mk(0, 0, 1, 32'h400,0, 32'h000, 32'h01E, 1);
      vec[16] = mk(0, 0, 0, 0,      0, 32'h000, 32'h400, 1);
      vec[17] = mk(0, 0, 1, 32'h20, 0, 32'h000, 32'h400, 1);
      vec[18] = mk(0, 0, 0, 0,      0, 32'h000, 32'h020, 0);
      vec[19] = mk(0, 0, 1, 32'h3F4,1, 32'h020, 32'h024, 0);
      vec[20] = mk(0, 0, 0, 0,      0, 32'h000, 32'h3F4, 0);
      vec[21] = mk(0, 0, 0, 0,      1, 32'h3F4, 32'h3F8, 0);
      vec[22] = mk(0, 1, 0, 0,      1, 32'h3F8, 32'h3FC, 0);
      vec[23] = mk(0, 1, 0, 0,      1, 32'h3F8, 32'h400, 0);
      vec[24] = mk(0, 0, 0, 0,      1, 32'h3F8, 32'h400, 1);
      vec[25] = mk(0, 0, 0, 0,      1, 32'h3FC, 32'h400, 1);
      vec[26] = mk(0, 0, 0, 0,      0, 32'h000, 32'h400, 1);
      vec[27] = mk(0, 0, 0, 0,      0, 32'h000, 32'h400, 1);

      model_reset();
      @(negedge clk);
      #1;

      // Directed table
      for (int i = 0; i < 28; i++) begin
         if (vec[i].rst) do_reset();
         chk($sformatf("v%0d_if_valid", i), {31'h0, if_valid}, {31'h0, vec[i].exp_valid});
         chk($sformatf("v%0d_if_pc", i), if_pc, vec[i].exp_pc);
         chk($sformatf("v%0d_if_instr", i), if_instr,
             vec[i].exp_valid ? img_word(vec[i].exp_pc) : 32'h0);
         chk($sformatf("v%0d_if_pc_plus4", i), if_pc_plus4,
             vec[i].exp_valid ? vec[i].exp_pc + 32'd4 : 32'h0);
         chk($sformatf("v%0d_imem_pc", i), imem_pc, vec[i].exp_imem);
         chk($sformatf("v%0d_fault", i), {31'h0, fetch_fault}, {31'h0, vec[i].exp_fault});
         run_cycle(vec[i].stall, vec[i].redir, vec[i].rpc);
      end

      // Asynchronous reset with a full queue, mid low phase
      do_reset();
      repeat (4) run_cycle(1'b1, 1'b0, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_if_valid", {31'h0, if_valid}, 32'h0);
      chk("arst_if_pc", if_pc, 32'h0);
      chk("arst_if_instr", if_instr, 32'h0);
      chk("arst_if_pc_plus4", if_pc_plus4, 32'h0);
      chk("arst_imem_pc", imem_pc, 32'h0);
      chk("arst_fault", {31'h0, fetch_fault}, 32'h0);
      model_reset();
      stall = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      run_cycle(1'b0, 1'b0, 32'h0);
      chk("arst_restart_pc", if_pc, 32'h0);
      chk("arst_restart_valid", {31'h0, if_valid}, 32'h1);
      run_cycle(1'b0, 1'b0, 32'h0);

      // Randomized traffic against the model
      do_reset();
      for (int n = 0; n < 800; n++) begin
         rpc = 32'h0;
         if ($urandom_range(0, 11) == 0) begin
            k = $urandom_range(0, 9);
            case (k)
               6:       rpc = 32'h3E8 + 4 * $urandom_range(0, 5);
               7:       rpc = 4 * $urandom_range(0, 255) + $urandom_range(1, 3);
               8:       rpc = 32'h400;
               9:       rpc = 32'hFFFF_FFFC;
               default: rpc = 4 * $urandom_range(0, 255);
            endcase
            run_cycle($urandom_range(0, 1) == 1, 1'b1, rpc);
         end else begin
            run_cycle($urandom_range(0, 2) == 0, 1'b0, 32'h0);
         end
      end
      compare_model();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
